// File: rtl/pool_stream_layer.sv
`default_nettype none
// ============================================================================
// Module      : pool_stream_layer
// Description : Streaming non-overlapping KxK pooling over all channels in
//               parallel. Pixels arrive one per handshake in raster order; one
//               pooled pixel leaves per completed window. Max or floor-average
//               is selected per frame. The output is saturated to the output
//               width and held under downstream backpressure.
// Ports       : clk          rising-edge clock
//               rst          asynchronous active-low reset
//               i_start      1-cycle frame start, latches i_mode (IDLE only)
//               i_mode       0 = max, 1 = floor-average
//               i_valid      i_data valid
//               o_ready      pixel accepted when i_valid && o_ready
//               i_data       one pixel, channel ch at [ch*DATATYPE_SIZE +: DATATYPE_SIZE]
//               o_valid      o_func_data valid
//               i_next_busy  downstream stall; transfer when o_valid && !i_next_busy
//               o_func_data  pooled pixel, channel ch at [ch*OUTPUT_DATATYPE_SIZE +: ...]
//               o_busy       high outside IDLE
//               o_done       1-cycle pulse once the frame is complete and drained
// Revision    : 1.0 - initial release
// ============================================================================
module pool_stream_layer #(
    parameter int DATATYPE_SIZE        = 4,
    parameter int OUTPUT_DATATYPE_SIZE = 4,
    parameter int INPUT_CHANNELS       = 10,
    parameter int IMG_WIDTH            = 22,
    parameter int KERNEL_DIM           = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            i_start,
    input  logic                                            i_mode,
    input  logic                                            i_valid,
    output logic                                            o_ready,
    input  logic [INPUT_CHANNELS*DATATYPE_SIZE-1:0]         i_data,
    output logic                                            o_valid,
    input  logic                                            i_next_busy,
    output logic [INPUT_CHANNELS*OUTPUT_DATATYPE_SIZE-1:0]  o_func_data,
    output logic                                            o_busy,
    output logic                                            o_done
);

    localparam int c_out_width = IMG_WIDTH / KERNEL_DIM;
    localparam int c_acc_w     = DATATYPE_SIZE + 2 * $clog2(KERNEL_DIM) + 1;
    localparam int c_res_w     = (c_acc_w > OUTPUT_DATATYPE_SIZE) ? c_acc_w : OUTPUT_DATATYPE_SIZE;
    localparam int c_cnt_w     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int c_k_w       = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
    localparam int c_ox_w      = (c_out_width > 1) ? $clog2(c_out_width) : 1;

    localparam logic [c_cnt_w-1:0] c_last_pos = c_cnt_w'(IMG_WIDTH - 1);
    // One bit wider than the counters: the trim limit may equal IMG_WIDTH.
    localparam logic [c_cnt_w:0]   c_trim_lim = (c_cnt_w + 1)'(c_out_width * KERNEL_DIM);
    localparam logic [c_k_w-1:0]   c_k_last   = c_k_w'(KERNEL_DIM - 1);
    localparam logic [c_acc_w-1:0] c_area     = c_acc_w'(KERNEL_DIM * KERNEL_DIM);
    localparam logic [c_res_w-1:0] c_out_max  = c_res_w'((64'd1 << OUTPUT_DATATYPE_SIZE) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_mode;
    logic [c_cnt_w-1:0]     r_row;
    logic [c_cnt_w-1:0]     r_col;
    logic [c_k_w-1:0]       r_kx;
    logic [c_k_w-1:0]       r_ky;
    logic [c_ox_w-1:0]      r_ox;
    logic [c_acc_w-1:0]     r_acc [INPUT_CHANNELS][c_out_width];

    logic                                           r_valid;
    logic [INPUT_CHANNELS*OUTPUT_DATATYPE_SIZE-1:0] r_data;

    logic                   w_out_free;
    logic                   w_accept;
    logic                   w_in_region;
    logic                   w_first;
    logic                   w_last;
    logic                   w_win_done;
    logic                   w_last_pix;
    logic [c_acc_w-1:0]     w_pix [INPUT_CHANNELS];
    logic [c_acc_w-1:0]     w_upd [INPUT_CHANNELS];
    logic [c_res_w-1:0]     w_res [INPUT_CHANNELS];
    logic [INPUT_CHANNELS*OUTPUT_DATATYPE_SIZE-1:0] w_sat;

    // ------------------------------------------------------------------------
    // Handshake and position decode
    // ------------------------------------------------------------------------
    // The output register has room when it is empty or is being emptied this
    // cycle; this is what lets a completed window load back-to-back with a
    // transfer, and what blocks acceptance while the register is stalled.
    assign w_out_free  = !r_valid || !i_next_busy;
    assign o_ready     = (r_state == ST_RUN) && w_out_free;
    assign w_accept    = i_valid && o_ready;

    // Pixels beyond the last whole window (odd-size trim) are consumed but
    // never touch the accumulators.
    assign w_in_region = ({1'b0, r_col} < c_trim_lim) && ({1'b0, r_row} < c_trim_lim);
    assign w_first     = (r_kx == '0) && (r_ky == '0);
    assign w_last      = (r_kx == c_k_last) && (r_ky == c_k_last);
    assign w_win_done  = w_accept && w_in_region && w_last;
    assign w_last_pix  = (r_row == c_last_pos) && (r_col == c_last_pos);

    // ------------------------------------------------------------------------
    // Per-channel datapath: accumulator update, result and saturation
    // ------------------------------------------------------------------------
    always_comb begin
        w_sat = '0;
        for (int ch = 0; ch < INPUT_CHANNELS; ch++) begin
            w_pix[ch] = c_acc_w'(i_data[ch*DATATYPE_SIZE +: DATATYPE_SIZE]);
            if (w_first) begin
                w_upd[ch] = w_pix[ch];
            end else if (r_mode) begin
                w_upd[ch] = r_acc[ch][r_ox] + w_pix[ch];
            end else begin
                w_upd[ch] = (w_pix[ch] > r_acc[ch][r_ox]) ? w_pix[ch] : r_acc[ch][r_ox];
            end
            // The result is formed from the updated value so the output
            // register can capture it on the same edge as the last pixel.
            if (r_mode) begin
                w_res[ch] = c_res_w'(w_upd[ch] / c_area);
            end else begin
                w_res[ch] = c_res_w'(w_upd[ch]);
            end
            if (w_res[ch] > c_out_max) begin
                w_sat[ch*OUTPUT_DATATYPE_SIZE +: OUTPUT_DATATYPE_SIZE] = {OUTPUT_DATATYPE_SIZE{1'b1}};
            end else begin
                w_sat[ch*OUTPUT_DATATYPE_SIZE +: OUTPUT_DATATYPE_SIZE] = w_res[ch][OUTPUT_DATATYPE_SIZE-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Raster position counters and mode latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= 1'b0;
            r_row  <= '0;
            r_col  <= '0;
            r_kx   <= '0;
            r_ky   <= '0;
            r_ox   <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_mode <= i_mode;
            r_row  <= '0;
            r_col  <= '0;
            r_kx   <= '0;
            r_ky   <= '0;
            r_ox   <= '0;
        end else if (w_accept) begin
            if (r_col == c_last_pos) begin
                r_col <= '0;
                r_kx  <= '0;
                r_ox  <= '0;
                r_row <= (r_row == c_last_pos) ? '0 : r_row + c_cnt_w'(1);
                r_ky  <= (r_ky == c_k_last) ? '0 : r_ky + c_k_w'(1);
            end else begin
                r_col <= r_col + c_cnt_w'(1);
                // ox may run past the last window inside the trim columns;
                // those pixels are discarded, and ox restarts at row wrap.
                if (r_kx == c_k_last) begin
                    r_kx <= '0;
                    r_ox <= r_ox + c_ox_w'(1);
                end else begin
                    r_kx <= r_kx + c_k_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Row accumulator: one entry per window column, per channel
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < INPUT_CHANNELS; ch++) begin
                for (int ox = 0; ox < c_out_width; ox++) begin
                    r_acc[ch][ox] <= '0;
                end
            end
        end else if (w_accept && w_in_region) begin
            for (int ch = 0; ch < INPUT_CHANNELS; ch++) begin
                r_acc[ch][r_ox] <= w_upd[ch];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_win_done) begin
            r_valid <= 1'b1;
            r_data  <= w_sat;
        end else if (!i_next_busy) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_func_data = r_data;

    // ------------------------------------------------------------------------
    // Frame control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && w_last_pix) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as the register empties, so o_done lands in the
                // cycle right after the final transfer.
                if (w_out_free) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_stream_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_stream_layer
// Description : Self-checking bench for pool_stream_layer. Three instances
//               cover 4x4 / 5x5 images and 4-bit / 2-bit outputs; expected
//               pooled pixels are queued when a frame is driven and popped as
//               the DUT transfers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_stream_layer;

    typedef struct packed {
        logic [1:0]  sel;     // 0: W=4/out4, 1: W=5/out4, 2: W=4/out2
        logic        mode;    // 0 max, 1 average
        logic [1:0]  pat;     // 0 ramp, 1 nine with last row/col 15, 2 all 15
        logic        poke;    // i_start + mode flip mid-frame
        logic        stall;   // 10-cycle stall at first o_valid
        logic [31:0] exp;     // four windows, byte k = {ch1, ch0}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_start [3];
    logic       s_mode  [3];
    logic       s_valid [3];
    logic [7:0] s_data  [3];
    logic       nbusy;

    logic       s_rdy [3];
    logic       s_val [3];
    logic       s_bsy [3];
    logic       s_dn  [3];
    logic [7:0] s_od  [3];

    logic       a_rdy, a_val, a_bsy, a_dn;
    logic       b_rdy, b_val, b_bsy, b_dn;
    logic       c_rdy, c_val, c_bsy, c_dn;
    logic [7:0] a_od, b_od;
    logic [3:0] c_od;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         last_xfer = 0;
    int         done_seen = 0;
    int         sel      = 0;
    bit         mon_en   = 0;
    bit         stall_req  = 0;
    bit         stall_done = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    vec_t       tbl [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pool_stream_layer #(.DATATYPE_SIZE(4), .OUTPUT_DATATYPE_SIZE(4), .INPUT_CHANNELS(2),
                        .IMG_WIDTH(4), .KERNEL_DIM(2)) dut_a (
        .clk(clk), .rst(rst), .i_start(s_start[0]), .i_mode(s_mode[0]),
        .i_valid(s_valid[0]), .o_ready(a_rdy), .i_data(s_data[0]), .o_valid(a_val),
        .i_next_busy(nbusy), .o_func_data(a_od), .o_busy(a_bsy), .o_done(a_dn));

    pool_stream_layer #(.DATATYPE_SIZE(4), .OUTPUT_DATATYPE_SIZE(4), .INPUT_CHANNELS(2),
                        .IMG_WIDTH(5), .KERNEL_DIM(2)) dut_b (
        .clk(clk), .rst(rst), .i_start(s_start[1]), .i_mode(s_mode[1]),
        .i_valid(s_valid[1]), .o_ready(b_rdy), .i_data(s_data[1]), .o_valid(b_val),
        .i_next_busy(nbusy), .o_func_data(b_od), .o_busy(b_bsy), .o_done(b_dn));

    pool_stream_layer #(.DATATYPE_SIZE(4), .OUTPUT_DATATYPE_SIZE(2), .INPUT_CHANNELS(2),
                        .IMG_WIDTH(4), .KERNEL_DIM(2)) dut_c (
        .clk(clk), .rst(rst), .i_start(s_start[2]), .i_mode(s_mode[2]),
        .i_valid(s_valid[2]), .o_ready(c_rdy), .i_data(s_data[2]), .o_valid(c_val),
        .i_next_busy(nbusy), .o_func_data(c_od), .o_busy(c_bsy), .o_done(c_dn));

    always_comb begin
        s_rdy[0] = a_rdy; s_rdy[1] = b_rdy; s_rdy[2] = c_rdy;
        s_val[0] = a_val; s_val[1] = b_val; s_val[2] = c_val;
        s_bsy[0] = a_bsy; s_bsy[1] = b_bsy; s_bsy[2] = c_bsy;
        s_dn[0]  = a_dn;  s_dn[1]  = b_dn;  s_dn[2]  = c_dn;
        s_od[0]  = a_od;  s_od[1]  = b_od;  s_od[2]  = {4'b0000, c_od};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] pix(input int pat, input int w, input int idx);
        logic [3:0] lo;
        logic [3:0] hi;
        int r;
        int c;
        r = idx / w;
        c = idx % w;
        case (pat)
            0: begin lo = 4'(idx); hi = 4'(15 - idx); end
            1: begin lo = (r == w - 1 || c == w - 1) ? 4'd15 : 4'd9; hi = lo; end
            default: begin lo = 4'd15; hi = 4'd15; end
        endcase
        return {hi, lo};
    endfunction

    // Scoreboard monitor: transfers, stall hold and o_ready under stall.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_hold_valid", s_val[sel], 1);
                check("stall_hold_data", s_od[sel], prev_data);
            end
            if (s_val[sel] && nbusy) check("stall_ready_low", s_rdy[sel], 0);
            if (s_val[sel] && !nbusy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_output: got %0h, expected no output (cycle %0d)", s_od[sel], cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_data", s_od[sel], mon_exp);
                end
                last_xfer = cyc;
            end
            if (s_dn[sel]) done_seen++;
            prev_stall = s_val[sel] && nbusy;
            prev_data  = s_od[sel];
        end
    end

    // Downstream stall generator.
    initial begin
        nbusy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_req && !stall_done && s_val[sel]) begin
                nbusy = 1'b1;
                repeat (10) @(posedge clk);
                #1 nbusy = 1'b0;
                stall_done = 1;
            end
        end
    end

    task automatic drive_pixel(input int w, input int pat, input int idx, input bit poke, input bit mode);
        int tries;
        bit acc;
        s_valid[sel] = 1'b1;
        s_data[sel]  = pix(pat, w, idx);
        if (poke) begin
            s_start[sel] = 1'b1;
            s_mode[sel]  = !mode;
        end
        tries = 0;
        acc   = 0;
        do begin
            @(negedge clk);
            acc = s_rdy[sel];
            @(posedge clk); #1;
            s_start[sel] = 1'b0;
            tries++;
        end while (!acc && tries < 100);
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: pixel %0d not accepted after %0d cycles", idx, tries);
        end
    endtask

    task automatic check_idle(input int d);
        check("rst_valid", s_val[d], 0);
        check("rst_ready", s_rdy[d], 0);
        check("rst_busy",  s_bsy[d], 0);
        check("rst_done",  s_dn[d],  0);
        check("rst_data",  s_od[d],  0);
    endtask

    task automatic run_frame(input vec_t v);
        int w;
        int d0;
        bit got;
        sel        = int'(v.sel);
        w          = (v.sel == 2'd1) ? 5 : 4;
        stall_req  = v.stall;
        stall_done = 0;
        d0         = done_seen;
        for (int k = 0; k < 4; k++) exp_q.push_back(v.exp[8*k +: 8]);
        @(posedge clk); #1;
        s_mode[sel]  = v.mode;
        s_start[sel] = 1'b1;
        @(posedge clk); #1;
        s_start[sel] = 1'b0;
        for (int idx = 0; idx < w * w; idx++) begin
            drive_pixel(w, int'(v.pat), idx, v.poke && (idx == 6), v.mode);
        end
        s_valid[sel] = 1'b0;
        s_mode[sel]  = v.mode;
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = s_dn[sel];
        end
        check("done_seen", got, 1);
        if (got) begin
            check("outputs_drained", exp_q.size(), 0);
            if (w % 2 == 0) check("done_latency", cyc - last_xfer, 1);
            @(negedge clk);
            check("done_one_cycle", s_dn[sel], 0);
            check("idle_after_done", s_bsy[sel], 0);
            check("done_count", done_seen - d0, 1);
        end
        exp_q.delete();
        stall_req = 0;
    endtask

    initial begin
        int d0;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            s_start[d] = 1'b0; s_mode[d] = 1'b0; s_valid[d] = 1'b0; s_data[d] = 8'h00;
        end
        tbl[0] = '{sel: 2'd0, mode: 1'b0, pat: 2'd0, poke: 1'b0, stall: 1'b0, exp: 32'h5F7DD7F5};
        tbl[1] = '{sel: 2'd0, mode: 1'b1, pat: 2'd0, poke: 1'b0, stall: 1'b0, exp: 32'h2C4AA4C2};
        tbl[2] = '{sel: 2'd0, mode: 1'b0, pat: 2'd0, poke: 1'b0, stall: 1'b1, exp: 32'h5F7DD7F5};
        tbl[3] = '{sel: 2'd1, mode: 1'b0, pat: 2'd1, poke: 1'b0, stall: 1'b0, exp: 32'h99999999};
        tbl[4] = '{sel: 2'd1, mode: 1'b1, pat: 2'd1, poke: 1'b0, stall: 1'b0, exp: 32'h99999999};
        tbl[5] = '{sel: 2'd2, mode: 1'b1, pat: 2'd2, poke: 1'b0, stall: 1'b0, exp: 32'h0F0F0F0F};
        tbl[6] = '{sel: 2'd2, mode: 1'b1, pat: 2'd0, poke: 1'b0, stall: 1'b0, exp: 32'h0B0F0F0E};
        tbl[7] = '{sel: 2'd0, mode: 1'b0, pat: 2'd0, poke: 1'b1, stall: 1'b0, exp: 32'h5F7DD7F5};
        tbl[8] = '{sel: 2'd0, mode: 1'b1, pat: 2'd2, poke: 1'b0, stall: 1'b0, exp: 32'hFFFFFFFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d);
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1;

        for (int v = 0; v < 9; v++) run_frame(tbl[v]);

        // Reset in the middle of a frame: window 0 comes out, then abort.
        sel = 0;
        d0  = done_seen;
        exp_q.push_back(8'hF5);
        @(posedge clk); #1;
        s_mode[0]  = 1'b0;
        s_start[0] = 1'b1;
        @(posedge clk); #1;
        s_start[0] = 1'b0;
        for (int idx = 0; idx < 7; idx++) drive_pixel(4, 0, idx, 0, 1'b0);
        s_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_idle(0);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_outputs", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_frame(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
